// File: rtl/nibble_serial_cmp_ctrl.sv
// Serial magnitude comparator: walks two WIDTH-bit operands one nibble per cycle, MSB first,
// through a single 4-bit greater/equal slice and exits on the first unequal nibble.
module nibble_serial_cmp_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = $clog2(NIB);
    localparam int unsigned SELW = IDXW + 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [IDXW-1:0]  idx, idx_nxt;
    logic [WIDTH-1:0] a_r, a_r_nxt;
    logic [WIDTH-1:0] b_r, b_r_nxt;
    logic             sgn_r, sgn_nxt;
    logic             busy_nxt, done_nxt, gt_nxt, eq_nxt, lt_nxt;

    logic [SELW-1:0]  sel;
    logic [3:0]       a_nib, b_nib, eqb;
    logic             msb_nib, nib_gt, nib_eq;

    // Compare slice; the top nibble gets its sign bit flipped in signed mode (offset binary)
    always_comb begin
        sel     = SELW'({idx, 2'b00});
        msb_nib = (idx == IDXW'(NIB - 1));
        a_nib   = a_r[sel +: 4];
        b_nib   = b_r[sel +: 4];
        if (sgn_r && msb_nib) begin
            a_nib[3] = ~a_nib[3];
            b_nib[3] = ~b_nib[3];
        end
        eqb    = ~(a_nib ^ b_nib);
        nib_eq = &eqb;
        nib_gt = (a_nib[3] & ~b_nib[3])
               | (eqb[3] & a_nib[2] & ~b_nib[2])
               | (eqb[3] & eqb[2] & a_nib[1] & ~b_nib[1])
               | (eqb[3] & eqb[2] & eqb[1] & a_nib[0] & ~b_nib[0]);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        a_r_nxt   = a_r;
        b_r_nxt   = b_r;
        sgn_nxt   = sgn_r;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        gt_nxt    = a_gt_b;
        eq_nxt    = a_eq_b;
        lt_nxt    = a_lt_b;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    a_r_nxt   = a;
                    b_r_nxt   = b;
                    sgn_nxt   = is_signed;
                    idx_nxt   = IDXW'(NIB - 1);
                    gt_nxt    = 1'b0;
                    eq_nxt    = 1'b0;
                    lt_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end else if (!nib_eq) begin
                    gt_nxt    = nib_gt;
                    lt_nxt    = ~nib_gt;
                    done_nxt  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (idx == '0) begin
                    eq_nxt    = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    idx_nxt = idx - IDXW'(1);
                end
            end
            ST_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            sgn_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_gt_b <= 1'b0;
            a_eq_b <= 1'b0;
            a_lt_b <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            a_r    <= a_r_nxt;
            b_r    <= b_r_nxt;
            sgn_r  <= sgn_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            a_gt_b <= gt_nxt;
            a_eq_b <= eq_nxt;
            a_lt_b <= lt_nxt;
        end
    end

endmodule
